// File: rtl/mul_unit.sv
// Iterative 32x32->32 multiply / multiply-accumulate for MUL and MLA.
// Consumes STEP_BITS multiplier bits per cycle and stops early once the multiplier is exhausted.
module mul_unit #(
  parameter int STEP_BITS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [31:0] accumulate,
  input  logic        acc_en,
  input  logic        set_flags,
  input  logic [31:0] dest_reg,
  input  logic [3:0]  cpsr_in,
  output logic        busy,
  output logic        done,
  output logic        regwrite,
  output logic [31:0] write_reg,
  output logic [31:0] write_data,
  output logic        negative_flag,
  output logic        zero_flag,
  output logic        carry_flag,
  output logic        overflow_flag
);

  // Only STEP_BITS = 8 is supported; four steps cover a full 32-bit multiplier.
  localparam int MAX_STEPS = 32 / STEP_BITS;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] acc_q;
  logic [31:0] rd_q;
  logic        sf_q;
  logic [3:0]  cpsr_q;
  logic [2:0]  count_q;

  logic [31:0] acc_next;
  logic [31:0] b_next;
  logic [2:0]  count_next;
  logic        last_step;
  logic [3:0]  flags_next;

  always_comb begin
    acc_next   = acc_q + a_q * {{(32-STEP_BITS){1'b0}}, b_q[STEP_BITS-1:0]};
    b_next     = b_q >> STEP_BITS;
    count_next = count_q + 3'd1;
    last_step  = (b_next == 32'd0) || (count_next == 3'(MAX_STEPS));
    // Carry and overflow always pass through; the ARM "unpredictable" C is treated as unchanged.
    flags_next = sf_q ? {acc_next[31], (acc_next == 32'd0), cpsr_q[1:0]} : cpsr_q;
  end

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see pre-edge values; the datapath is reset too so an abort leaves no stale result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      rd_q          <= '0;
      sf_q          <= 1'b0;
      cpsr_q        <= '0;
      count_q       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      regwrite      <= 1'b0;
      write_reg     <= '0;
      write_data    <= '0;
      negative_flag <= 1'b0;
      zero_flag     <= 1'b0;
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= operand_a;
            b_q     <= operand_b;
            acc_q   <= acc_en ? accumulate : 32'd0;
            rd_q    <= dest_reg;
            sf_q    <= set_flags;
            cpsr_q  <= cpsr_in;
            count_q <= '0;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end

        CALC: begin
          a_q     <= a_q << STEP_BITS;
          b_q     <= b_next;
          acc_q   <= acc_next;
          count_q <= count_next;
          if (last_step) begin
            state         <= DONE;
            done          <= 1'b1;
            regwrite      <= 1'b1;
            write_data    <= acc_next;
            write_reg     <= rd_q;
            negative_flag <= flags_next[3];
            zero_flag     <= flags_next[2];
            carry_flag    <= flags_next[1];
            overflow_flag <= flags_next[0];
          end
        end

        DONE: begin
          // Any start seen here is dropped; the unit only listens in IDLE.
          done     <= 1'b0;
          regwrite <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed vector table, control-corner sequences,
// and random operations compared against an arithmetic reference model.
module tb_mul_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] accumulate;
  logic        acc_en;
  logic        set_flags;
  logic [31:0] dest_reg;
  logic [3:0]  cpsr_in;
  logic        busy;
  logic        done;
  logic        regwrite;
  logic [31:0] write_reg;
  logic [31:0] write_data;
  logic        negative_flag;
  logic        zero_flag;
  logic        carry_flag;
  logic        overflow_flag;

  mul_unit #(.STEP_BITS(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .accumulate    (accumulate),
    .acc_en        (acc_en),
    .set_flags     (set_flags),
    .dest_reg      (dest_reg),
    .cpsr_in       (cpsr_in),
    .busy          (busy),
    .done          (done),
    .regwrite      (regwrite),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .negative_flag (negative_flag),
    .zero_flag     (zero_flag),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] acc;
    logic        acc_en;
    logic        sf;
    logic [31:0] rd;
    logic [3:0]  cpsr;
    logic [31:0] exp_data;
    logic [3:0]  exp_flags;
    int          exp_n;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int regwrite_count = 0;

  // Each regwrite pulse lasts one full cycle, so counting on the falling edge sees it once.
  always @(negedge clock) if (regwrite === 1'b1) regwrite_count++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] flags_out();
    return {negative_flag, zero_flag, carry_flag, overflow_flag};
  endfunction

  // Reference model: plain arithmetic on the whole operands.
  function automatic int model_steps(input logic [31:0] b);
    int len = 0;
    for (int i = 0; i < 32; i++) if (b[i]) len = i + 1;
    return (len == 0) ? 1 : (len + 7) / 8;
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic [63:0] full;
    full = 64'(v.a) * 64'(v.b) + (v.acc_en ? 64'(v.acc) : 64'd0);
    r.exp_data  = full[31:0];
    r.exp_flags = v.sf ? {r.exp_data[31], (r.exp_data == 32'd0), v.cpsr[1:0]} : v.cpsr;
    r.exp_n     = model_steps(v.b);
    return r;
  endfunction

  task automatic drive(input vec_t v);
    operand_a  = v.a;
    operand_b  = v.b;
    accumulate = v.acc;
    acc_en     = v.acc_en;
    set_flags  = v.sf;
    dest_reg   = v.rd;
    cpsr_in    = v.cpsr;
  endtask

  task automatic scramble();
    operand_a  = $urandom;
    operand_b  = $urandom;
    accumulate = $urandom;
    acc_en     = 1'($urandom);
    set_flags  = 1'($urandom);
    dest_reg   = $urandom;
    cpsr_in    = 4'($urandom);
  endtask

  // Issues one op from IDLE and checks latency, result, and the single-cycle done.
  task automatic run_op(input vec_t v, input string tag);
    int edges = 0;
    drive(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    scramble();
    check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && edges < 12) begin
      tick();
      edges++;
    end
    check({tag, "_latency"}, 32'(edges), 32'(v.exp_n));
    check({tag, "_regwrite"}, 32'(regwrite), 32'd1);
    check({tag, "_data"}, write_data, v.exp_data);
    check({tag, "_reg"}, write_reg, v.rd);
    check({tag, "_flags"}, 32'(flags_out()), 32'(v.exp_flags));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    tick();
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
    check({tag, "_data_hold"}, write_data, v.exp_data);
  endtask

  vec_t table_v[8];
  vec_t v;
  int   rw_before;
  int   edges;

  initial begin
    //           a             b             acc  en   sf   rd   cpsr     exp_data      flags    n
    table_v[0] = '{32'd3,        32'd5,        0, 1'b0, 1'b1, 2,  4'b0000, 32'h0000000F, 4'b0000, 1};
    table_v[1] = '{32'h12345678, 32'h01000001, 0, 1'b0, 1'b1, 5,  4'b0000, 32'h8A345678, 4'b1000, 4};
    table_v[2] = '{32'hFFFFFFFF, 32'd1,        1, 1'b1, 1'b1, 7,  4'b0011, 32'h00000000, 4'b0111, 1};
    table_v[3] = '{32'd7,        32'd0,        0, 1'b0, 1'b0, 9,  4'b0110, 32'h00000000, 4'b0110, 1};
    table_v[4] = '{32'd2,        32'h00000100, 0, 1'b0, 1'b1, 3,  4'b1101, 32'h00000200, 4'b0001, 2};
    table_v[5] = '{32'd1,        32'h00010000, 5, 1'b1, 1'b0, 14, 4'b1010, 32'h00010005, 4'b1010, 3};
    table_v[6] = '{32'd1,        32'h80000000, 0, 1'b0, 1'b1, 1,  4'b0100, 32'h80000000, 4'b1000, 4};
    table_v[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 9, 1'b0, 1'b1, 15, 4'b0010, 32'h00000001, 4'b0010, 4};

    start = 1'b0;
    reset = 1'b1;
    drive(table_v[0]);

    // Reset held for two cycles with start asserted: nothing is accepted.
    start = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_regwrite", 32'(regwrite), 32'd0);
    check("rst_data", write_data, 32'd0);
    check("rst_reg", write_reg, 32'd0);
    check("rst_flags", 32'(flags_out()), 32'd0);
    start = 1'b0;
    reset = 1'b0;
    tick();
    check("rst_start_dropped", 32'(busy), 32'd0);

    // Directed table; consecutive ops also exercise back-to-back acceptance.
    for (int i = 0; i < 8; i++) run_op(table_v[i], $sformatf("vec%0d", i));

    // Second start while busy (held through DONE) is ignored.
    rw_before = regwrite_count;
    v = table_v[1];
    drive(v);
    start = 1'b1;
    tick();
    drive(table_v[0]);
    edges = 0;
    while (done !== 1'b1 && edges < 12) begin
      tick();
      edges++;
    end
    check("busy_start_latency", 32'(edges), 32'd4);
    check("busy_start_data", write_data, v.exp_data);
    tick();
    start = 1'b0;
    check("busy_start_idle", 32'(busy), 32'd0);
    tick();
    tick();
    check("busy_start_not_taken", 32'(busy), 32'd0);
    check("busy_start_one_pulse", 32'(regwrite_count - rw_before), 32'd1);

    // Reset during the 2nd CALC cycle of a 4-step op aborts without a write.
    rw_before = regwrite_count;
    drive(table_v[7]);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_data", write_data, 32'd0);
    check("abort_reg", write_reg, 32'd0);
    check("abort_flags", 32'(flags_out()), 32'd0);
    check("abort_no_write", 32'(regwrite_count - rw_before), 32'd0);
    // New op accepted on the first edge after reset is released.
    reset = 1'b0;
    run_op(table_v[0], "post_reset");
    check("post_reset_one_pulse", 32'(regwrite_count - rw_before), 32'd1);

    // Random ops against the arithmetic model, with varied multiplier lengths.
    for (int i = 0; i < 40; i++) begin
      vec_t r;
      r.a      = $urandom;
      r.b      = $urandom >> $urandom_range(0, 32);
      r.acc    = $urandom;
      r.acc_en = 1'($urandom);
      r.sf     = 1'($urandom);
      r.rd     = $urandom_range(0, 15);
      r.cpsr   = 4'($urandom);
      if (i % 8 == 0) begin
        r.a = 32'd0;
        r.acc_en = 1'b0;
      end
      run_op(model(r), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative multiply / multiply-accumulate unit for the ARM7TDMI core (MUL, MLA; 32-bit result). It sits between operand read and register writeback. It consumes two register-file read values, plus an optional accumulate value. Several cycles later it presents a single-cycle write of the product into the `registers` block, together with updated condition flags. It uses 8 multiplier bits per cycle with early termination, giving 1–4 compute cycles.

## Interface
Parameters:
- `STEP_BITS`, 8: multiplier bits consumed per iteration. Only the value 8 is supported.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request a multiply; sampled only while idle
- `operand_a`  in  32  multiplicand (Rm value)
- `operand_b`  in  32  multiplier (Rs value)
- `accumulate`  in  32  addend (Rn value), used when `acc_en`=1
- `acc_en`  in  1  1 = MLA, 0 = MUL
- `set_flags`  in  1  S bit; 1 = update N,Z from the result
- `dest_reg`  in  32  destination register number (Rd), forwarded to `write_reg`
- `cpsr_in`  in  4  current flags {N,Z,C,V}
- `busy`  out  1  high whenever the unit is not idle
- `done`  out  1  one-cycle pulse; the result is valid in this cycle
- `regwrite`  out  1  register-file write enable; equal to `done`
- `write_reg`  out  32  latched `dest_reg`
- `write_data`  out  32  low 32 bits of a*b (+acc)
- `negative_flag`, `zero_flag`, `carry_flag`, `overflow_flag`  out  1 each  flags presented to the register file

## Operation
States are IDLE, CALC and DONE.

**IDLE**
- `busy`=0.
- When `start`=1:
  - latch a, b, `dest_reg`, `set_flags` and `cpsr_in`;
  - `acc` ← `acc_en` ? `accumulate` : 0;
  - step counter ← 0;
  - go to CALC.

**CALC (one step per edge)**
- `acc` ← (`acc` + a × b[7:0]) mod 2^32
- a ← a << 8
- b ← b >> 8
- count ← count + 1
- Go to DONE when the shifted b is 0 or count reaches 4. Otherwise stay in CALC.
- Step count N = max(1, ceil(bitlen(b)/8)). b = 0 still takes 1 step.

**DONE (exactly one cycle)**
- `done`=1, `regwrite`=1, `write_data`=`acc`, `write_reg`=latched Rd.
- Next state is IDLE unconditionally.

**Flags (registered, updated on entry to DONE)**
- If `set_flags`=1:
  - N = `acc`[31]
  - Z = (`acc` == 0)
  - C = `cpsr_in`.C
  - V = `cpsr_in`.V
- If `set_flags`=0: all four flags equal the latched `cpsr_in`.
- C is always preserved. The ARM "unpredictable" carry is defined here as unchanged.

Signedness is irrelevant because only the low 32 bits are produced. Signed and unsigned results are identical.

## Timing
- **Reset values:**
  - state = IDLE
  - `busy`=0, `done`=0, `regwrite`=0
  - `write_reg`=0, `write_data`=0
  - all flags = 0
- **Latency:**
  - `start` is sampled at edge E0;
  - CALC steps occur on edges E1..EN;
  - `done` is high from EN until EN+1.
  - Total is N+1 edges from start to the end of `done`: MUL with 0 < b < 256 finishes in 2 edges, and a full 32-bit b in 5.
- `busy` rises the cycle after the accepting edge and stays high through DONE.
- `start` while `busy`=1, including during DONE, is ignored. No queueing.
- **Back-to-back:** a `start` presented in the cycle after DONE (state IDLE) is accepted. Maximum throughput is one op per N+2 cycles.
- Operand inputs may change freely after the accepting edge; only latched copies are used.
- `write_reg`, `write_data` and the flags hold their last values outside DONE. Consumers must qualify them with `regwrite`.
- **Reset mid-operation:** abort to IDLE on that edge. No `regwrite` is produced and all outputs return to their reset values.
- **Simultaneous `reset` and `start`:** reset wins and the request is dropped.

## Test plan
- **Reset:** assert `reset` for 2 cycles.
  - `busy`, `done`, `regwrite`, `write_data` and all flags are 0.
  - A `start` during reset is not accepted.
- **Short MUL:** a=3, b=5, `set_flags`=1, Rd=2.
  - `done` occurs 2 edges after start.
  - `write_reg`=2, `write_data`=0x0000000F, N=0, Z=0.
- **Full-length MUL:** a=0x12345678, b=0x01000001, `set_flags`=1.
  - `done` occurs 5 edges after start.
  - `write_data`=0x8A345678, N=1, Z=0.
- **MLA wrap to zero:** a=0xFFFFFFFF, b=1, `accumulate`=1, `acc_en`=1, `set_flags`=1, `cpsr_in`=4'b0011.
  - Result 0x00000000.
  - Flags N=0, Z=1, C=1, V=1, after 2 edges.
- **Flag passthrough:** `set_flags`=0, `cpsr_in`=4'b0110, a=7, b=0.
  - `write_data`=0.
  - Flags N=0, Z=1, C=1, V=0, taken from `cpsr_in`.
- **Control corners:**
  - A second `start` while busy is ignored: exactly one `regwrite` pulse, carrying the first op's result.
  - `reset` asserted in the 2nd CALC cycle of a 4-step op: no `regwrite` occurs.
  - A new op is accepted on the first edge after reset is released.
